fp_mul_sched: RTL and testbench
===============================

FP_MUL_SCHED -- requirements
Module: fp_mul_sched

Interface
REQ-001 The block SHALL have parameter n_exp, default 8, meaning exponent field width.
REQ-002 The block SHALL have parameter n_sig, default 23, meaning stored significand field width.
REQ-003 The block SHALL have parameter n_req, default 4, meaning number of requesters (2..8).
REQ-004 The block SHALL define W = n_exp+n_sig+1 and IW = clog2(n_req) for port widths.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning a synchronous, active-high reset.
REQ-007 The block SHALL have port req_valid, input, n_req, meaning per-requester operand valid.
REQ-008 The block SHALL have port req_ready, output, n_req, meaning per-requester operand accepted this cycle.
REQ-009 The block SHALL have port req_a, input, n_req*W, meaning packed operand A; requester i at bits [i*W +: W].
REQ-010 The block SHALL have port req_b, input, n_req*W, meaning packed operand B, same packing as req_a.
REQ-011 The block SHALL have port rsp_valid, output, 1, meaning result valid.
REQ-012 The block SHALL have port rsp_ready, input, 1, meaning consumer accepts the result.
REQ-013 The block SHALL have port rsp_id, output, IW, meaning index of the requester that owns the result.
REQ-014 The block SHALL have port rsp_p, output, W, meaning product word.
REQ-015 The block SHALL have port rsp_flags, output, 6, meaning the class flag vector from fp_mul, in the codebase flag order.
REQ-016 The block SHALL have port op_count, output, 16, meaning count of results delivered.

Function
REQ-017 The block SHALL instantiate exactly one fp_mul and share it among all requesters.
REQ-018 The pipeline SHALL have two registered stages: S1 (issue: valid, id, a, b) and S2 (result: valid, id, p, flags); fp_mul sits between S1 and S2.
REQ-019 The grant SHALL be round-robin: search starts at pointer ptr, and the first asserted req_valid index modulo n_req wins.
REQ-020 req_ready SHALL be one-hot or zero: only the granted index, and only when S1 advances this cycle.
REQ-021 S2 SHALL advance when S2 is empty or rsp_ready=1; S1 SHALL advance when S1 is empty or S2 advances.
REQ-022 On S1 advance with a grant, S1 SHALL load the granted id, a and b, set valid, and ptr SHALL become (id+1) mod n_req.
REQ-023 On S1 advance without a grant, S1.valid SHALL clear and ptr SHALL hold.
REQ-024 On S2 advance, S2 SHALL load S1.valid, S1.id and the fp_mul outputs p and p_flags.
REQ-025 When S2 does not advance, all S2 and S1 contents SHALL hold unchanged (no drop, no duplicate).
REQ-026 Latency SHALL be 2 cycles: an operand accepted at edge t yields rsp_valid=1 after edge t+1, with no backpressure.
REQ-027 Sustained throughput SHALL be one operation per cycle with rsp_ready held high.
REQ-028 rsp_valid, rsp_id, rsp_p and rsp_flags SHALL be driven directly from S2 registers.
REQ-029 Results SHALL leave in grant order, and SHALL be bit-exact to fp_mul for every operand class (NaN, inf, zero, subnormal, normal).
REQ-030 op_count SHALL increment when rsp_valid and rsp_ready are both 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-031 req_ready SHALL depend on req_valid, ptr and pipeline state only; rsp_ready-to-req_ready combinational path is permitted.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL clear S1.valid, S2.valid, ptr, op_count, rsp_id, rsp_p and rsp_flags to 0, discarding in-flight operations.
REQ-033 While rst=1, req_ready SHALL be all zero.
REQ-034 The first grant after rst deasserts SHALL search from index 0.

Verification
REQ-035 The bench SHALL cover fp32 single op: req 0 sends a=0x3FC00000, b=0x40000000 -> two cycles later rsp_valid=1, rsp_id=0, rsp_p=0x40400000, flag norm set, and op_count=1 after the handshake.
REQ-036 The bench SHALL cover contention: all 4 req_valid held high with rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, and results return with rsp_id 0,1,2,3,0 in that order.
REQ-037 The bench SHALL cover backpressure: rsp_ready=0, requesters 1 and 2 valid -> two ops fill S1/S2, req_ready=0 thereafter; rsp_ready=1 drains id 1 then id 2 with nothing lost.
REQ-038 The bench SHALL cover the special case a=0x7F800000, b=0x00000000 -> rsp_p=0x7FC00000, qnan flag set.
REQ-039 The bench SHALL cover reset mid-flight: rst pulsed one cycle with S1 and S2 full -> rsp_valid=0 next cycle, op_count=0, and the next grant goes to the lowest valid index.
REQ-040 The bench SHALL cover op_count wrap: preload 0xFFFF deliveries (or force) and complete one handshake -> op_count=0x0000.

Source files
------------

// File: rtl/fp_mul_sched.sv
// fp_mul_sched: shares one combinational fp_mul among n_req requesters.
//   clk, rst            : clock and synchronous active-high reset
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot or zero)
//   req_a/req_b         : packed operands, requester i at [i*W +: W]
//   rsp_valid/rsp_ready : result handshake; rsp_id owns the result
//   rsp_p/rsp_flags     : product word and its class flags
//   op_count            : wrapping count of delivered results
// Flag order: [0] zero, [1] subnormal, [2] normal, [3] inf, [4] qnan, [5] invalid.

module fp_mul_sched #(
    parameter int unsigned n_exp = 8,
    parameter int unsigned n_sig = 23,
    parameter int unsigned n_req = 4,
    localparam int unsigned W    = n_exp + n_sig + 1,
    localparam int unsigned IW   = $clog2(n_req)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [n_req-1:0]   req_valid,
    output logic [n_req-1:0]   req_ready,
    input  logic [n_req*W-1:0] req_a,
    input  logic [n_req*W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IW-1:0]      rsp_id,
    output logic [W-1:0]       rsp_p,
    output logic [5:0]         rsp_flags,
    output logic [15:0]        op_count
);

    logic          s1_valid_q, s2_valid_q;
    logic [IW-1:0] s1_id_q, ptr_q, ptr_d, gnt_id;
    logic [W-1:0]  s1_a_q, s1_b_q, issue_a, issue_b, mul_p;
    logic [5:0]    mul_flags;
    logic          gnt_valid, s1_adv, s2_adv;
    logic [15:0]   op_count_q;

    assign s2_adv = !s2_valid_q || rsp_ready;
    assign s1_adv = !s1_valid_q || s2_adv;

    // Round-robin search starting at ptr; first valid index wins.
    always_comb begin
        int unsigned idx;
        gnt_valid = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        for (int unsigned k = 0; k < n_req; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= n_req) idx = idx - n_req;
            if (!gnt_valid && req_valid[IW'(idx)]) begin
                gnt_valid = 1'b1;
                gnt_id    = IW'(idx);
            end
        end
    end

    always_comb begin
        issue_a = '0;
        issue_b = '0;
        for (int unsigned i = 0; i < n_req; i++) begin
            if (gnt_id == IW'(i)) begin
                issue_a = req_a[i*W +: W];
                issue_b = req_b[i*W +: W];
            end
        end
        ptr_d     = (gnt_id == IW'(n_req - 1)) ? '0 : gnt_id + IW'(1);
        req_ready = (gnt_valid && s1_adv && !rst) ? (n_req'(1) << gnt_id) : '0;
    end

    fp_mul #(
        .n_exp (n_exp),
        .n_sig (n_sig)
    ) u_fp_mul (
        .a       (s1_a_q),
        .b       (s1_b_q),
        .p       (mul_p),
        .p_flags (mul_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_id_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            rsp_id     <= '0;
            rsp_p      <= '0;
            rsp_flags  <= '0;
            ptr_q      <= '0;
            op_count_q <= '0;
        end else begin
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                rsp_id     <= s1_id_q;
                rsp_p      <= mul_p;
                rsp_flags  <= mul_flags;
            end
            if (s1_adv) begin
                s1_valid_q <= gnt_valid;
                if (gnt_valid) begin
                    s1_id_q <= gnt_id;
                    s1_a_q  <= issue_a;
                    s1_b_q  <= issue_b;
                    ptr_q   <= ptr_d;
                end
            end
            if (s2_valid_q && rsp_ready) op_count_q <= op_count_q + 16'd1;
        end
    end

    assign rsp_valid = s2_valid_q;
    assign op_count  = op_count_q;

endmodule

// fp_mul: combinational IEEE-754 style multiply, round-to-nearest-even,
// full subnormal support, canonical quiet NaN output.
//   a, b    : operands; p : product; p_flags : class flags of p (order above)
module fp_mul #(
    parameter int unsigned n_exp = 8,
    parameter int unsigned n_sig = 23,
    localparam int unsigned W    = n_exp + n_sig + 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic [5:0]   p_flags
);

    localparam int unsigned PW   = 2 * (n_sig + 1);
    localparam int unsigned LW   = $clog2(PW) + 1;
    localparam int unsigned EW   = ((n_exp > LW) ? n_exp : LW) + 3;
    localparam int unsigned Bias = (1 << (n_exp - 1)) - 1;
    localparam int unsigned EMax = (1 << n_exp) - 1;

    logic               sa, sb, sp;
    logic [n_exp-1:0]   ea, eb, ea_eff, eb_eff, e_field;
    logic [n_sig-1:0]   ma, mb;
    logic [n_sig:0]     sig_a, sig_b;
    logic [PW-1:0]      prod, norm, shifted;
    logic [LW-1:0]      lz;
    logic [EW-1:0]      e_s, rsh;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, invalid, is_nan;
    logic               lost, lsb, guard, sticky, overflow;
    logic [n_exp+n_sig-1:0] mag;

    assign {sa, ea, ma} = a;
    assign {sb, eb, mb} = b;
    assign sp     = sa ^ sb;
    assign a_nan  = (&ea) && (|ma);
    assign b_nan  = (&eb) && (|mb);
    assign a_inf  = (&ea) && !(|ma);
    assign b_inf  = (&eb) && !(|mb);
    assign a_zero = !(|ea) && !(|ma);
    assign b_zero = !(|eb) && !(|mb);
    // Subnormals share the minimum exponent with an implicit 0 instead of 1.
    assign sig_a  = {|ea, ma};
    assign sig_b  = {|eb, mb};
    assign ea_eff = (|ea) ? ea : n_exp'(1);
    assign eb_eff = (|eb) ? eb : n_exp'(1);
    assign prod   = PW'(sig_a) * PW'(sig_b);
    assign is_nan = a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf);
    assign invalid = (a_inf && b_zero) || (a_zero && b_inf) ||
                     (a_nan && !ma[n_sig-1]) || (b_nan && !mb[n_sig-1]);

    always_comb begin
        lz = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            if (prod[i]) lz = LW'(PW - 1 - i);
        end
        norm     = prod << lz;
        e_s      = EW'(ea_eff) + EW'(eb_eff) - EW'(Bias) + EW'(1) - EW'(lz);
        overflow = !e_s[EW-1] && (e_s >= EW'(EMax));
        e_field  = '0;
        rsh      = '0;
        shifted  = norm;
        lost     = 1'b0;
        if (e_s[EW-1] || (e_s == '0)) begin
            // Below the normal range: denormalise, keeping shifted-out bits as sticky.
            rsh = EW'(1) - e_s;
            if (rsh > EW'(PW)) rsh = EW'(PW);
            shifted = norm >> rsh;
            lost    = |(norm & ~({PW{1'b1}} << rsh));
        end else begin
            e_field = e_s[n_exp-1:0];
        end
        lsb    = shifted[PW-1-n_sig];
        guard  = shifted[PW-2-n_sig];
        sticky = (|shifted[PW-3-n_sig:0]) || lost;
        // Rounding carry ripples into the exponent (subnormal->normal, max->inf).
        mag = {e_field, shifted[PW-2 -: n_sig]} +
              (n_exp + n_sig)'(guard && (sticky || lsb));

        if (is_nan)                          p = {1'b0, {n_exp{1'b1}}, 1'b1, {(n_sig-1){1'b0}}};
        else if (a_inf || b_inf || overflow) p = {sp, {n_exp{1'b1}}, {n_sig{1'b0}}};
        else if (a_zero || b_zero)           p = {sp, {(n_exp+n_sig){1'b0}}};
        else                                 p = {sp, mag};

        p_flags = '0;
        if (is_nan) begin
            p_flags[4] = 1'b1;
            p_flags[5] = invalid;
        end else if (&p[W-2 -: n_exp]) begin
            p_flags[3] = 1'b1;
        end else if (|p[W-2 -: n_exp]) begin
            p_flags[2] = 1'b1;
        end else if (|p[n_sig-1:0]) begin
            p_flags[1] = 1'b1;
        end else begin
            p_flags[0] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_mul_sched.sv
// Directed bench for fp_mul_sched (fp32, 4 requesters).
module tb_fp_mul_sched;

    logic         clk, rst;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_p;
    logic [5:0]   rsp_flags;
    logic [15:0]  op_count;
    int checks, errors;

    fp_mul_sched #(.n_exp(8), .n_sig(23), .n_req(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_flags (rsp_flags),
        .op_count  (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issues one op from requester id and waits (bounded) for its result.
    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          output logic [1:0] got_id, output logic [31:0] got_p,
                          output logic [5:0] got_f, output bit timed_out);
        int n;
        timed_out = 1'b0;
        set_op(id, a, b);
        req_valid = 4'b0001 << id;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin tick(); n++; end
        tick();
        req_valid = 4'b0000;
        n = 0;
        while (!rsp_valid && n < 20) begin tick(); n++; end
        if (!rsp_valid) timed_out = 1'b1;
        got_id = rsp_id;
        got_p  = rsp_p;
        got_f  = rsp_flags;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL reset_op_count got %h want 0000", op_count); end
        checks++; if ({rsp_id, rsp_p, rsp_flags} !== 40'h0) begin errors++; $display("FAIL reset_rsp_regs got %h/%h/%b want 0", rsp_id, rsp_p, rsp_flags); end
        req_valid = 4'b0000;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        set_op(0, 32'h3FC00000, 32'h40000000);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        tick();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", rsp_id); end
        checks++; if (rsp_p !== 32'h40400000) begin errors++; $display("FAIL single_p got %h want 40400000", rsp_p); end
        checks++; if (rsp_flags !== 6'b000100) begin errors++; $display("FAIL single_flags got %b want 000100", rsp_flags); end
        checks++; if (op_count !== 16'd0) begin errors++; $display("FAIL single_cnt_pre got %0d want 0", op_count); end
        tick();
        checks++; if (op_count !== 16'd1) begin errors++; $display("FAIL single_cnt got %0d want 1", op_count); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_empty got %b want 0", rsp_valid); end
    endtask

    task automatic test_contention();
        logic [31:0] exp_p [4];
        exp_p[0] = 32'h40000000; exp_p[1] = 32'h40800000;
        exp_p[2] = 32'h40C00000; exp_p[3] = 32'h41000000;
        do_reset();
        set_op(0, 32'h3F800000, 32'h40000000);
        set_op(1, 32'h40000000, 32'h40000000);
        set_op(2, 32'h40400000, 32'h40000000);
        set_op(3, 32'h40800000, 32'h40000000);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int c = 0; c < 7; c++) begin
            if (c == 5) req_valid = 4'b0000;
            #1;
            if (c < 5) begin
                checks++; if (req_ready !== (4'b0001 << (c % 4))) begin errors++; $display("FAIL contention_grant%0d got %b want %b", c, req_ready, 4'b0001 << (c % 4)); end
            end
            tick();
            if (c >= 1 && c <= 5) begin
                checks++; if (!rsp_valid || rsp_id !== 2'((c - 1) % 4) || rsp_p !== exp_p[(c - 1) % 4]) begin
                    errors++; $display("FAIL contention_rsp%0d got v%b id%0d %h want v1 id%0d %h", c, rsp_valid, rsp_id, rsp_p, (c - 1) % 4, exp_p[(c - 1) % 4]);
                end
            end else if (c == 6) begin
                checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL contention_drained got %b want 0", rsp_valid); end
            end
        end
        checks++; if (op_count !== 16'd5) begin errors++; $display("FAIL contention_cnt got %0d want 5", op_count); end
    endtask

    task automatic test_back_to_back_backpressure();
        set_op(1, 32'h3FC00000, 32'h3FC00000);
        set_op(2, 32'hC0000000, 32'h40400000);
        rsp_ready = 1'b0;
        req_valid = 4'b0110;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1 got %b want 0010", req_ready); end
        tick();
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant2 got %b want 0100", req_ready); end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin
                errors++; $display("FAIL bp_hold%0d got ready %b v%b id%0d want 0000 v1 id1", i, req_ready, rsp_valid, rsp_id);
            end
            tick();
        end
        checks++; if (rsp_p !== 32'h40100000) begin errors++; $display("FAIL bp_p1 got %h want 40100000", rsp_p); end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_p !== 32'hC0C00000) begin
            errors++; $display("FAIL bp_p2 got v%b id%0d %h want v1 id2 c0c00000", rsp_valid, rsp_id, rsp_p);
        end
        tick();
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd7) begin
            errors++; $display("FAIL bp_drain got v%b cnt%0d want v0 cnt7", rsp_valid, op_count);
        end
    endtask

    task automatic test_special();
        logic [1:0]  gid;
        logic [31:0] gp;
        logic [5:0]  gf;
        bit          to;
        run_op(3, 32'h7F800000, 32'h00000000, gid, gp, gf, to);
        checks++; if (to || gid !== 2'd3 || gp !== 32'h7FC00000 || gf !== 6'b110000) begin
            errors++; $display("FAIL special_inf_zero got to%b id%0d %h %b want id3 7fc00000 110000", to, gid, gp, gf);
        end
        run_op(0, 32'h00000001, 32'h40000000, gid, gp, gf, to);
        checks++; if (to || gp !== 32'h00000002 || gf !== 6'b000010) begin
            errors++; $display("FAIL special_subnormal got to%b %h %b want 00000002 000010", to, gp, gf);
        end
        run_op(1, 32'h00000000, 32'hC0400000, gid, gp, gf, to);
        checks++; if (to || gp !== 32'h80000000 || gf !== 6'b000001) begin
            errors++; $display("FAIL special_zero got to%b %h %b want 80000000 000001", to, gp, gf);
        end
        run_op(2, 32'h7F000000, 32'h40000000, gid, gp, gf, to);
        checks++; if (to || gp !== 32'h7F800000 || gf !== 6'b001000) begin
            errors++; $display("FAIL special_overflow got to%b %h %b want 7f800000 001000", to, gp, gf);
        end
    endtask

    task automatic test_reset_midflight();
        set_op(2, 32'h3F800000, 32'h3F800000);
        set_op(3, 32'h3F800000, 32'h3F800000);
        set_op(1, 32'h40000000, 32'h40400000);
        rsp_ready = 1'b0;
        req_valid = 4'b1100;
        tick();
        tick();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL midrst_full got %b want 1", rsp_valid); end
        req_valid = 4'b0110;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL midrst_ready got %b want 0000", req_ready); end
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        checks++; if (rsp_valid !== 1'b0 || op_count !== 16'd0) begin
            errors++; $display("FAIL midrst_clear got v%b cnt%0d want v0 cnt0", rsp_valid, op_count);
        end
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL midrst_grant got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0000;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_p !== 32'h40C00000) begin
            errors++; $display("FAIL midrst_rsp got v%b id%0d %h want v1 id1 40c00000", rsp_valid, rsp_id, rsp_p);
        end
        tick();
    endtask

    task automatic test_wrap();
        bit reached;
        do_reset();
        set_op(0, 32'h3F800000, 32'h3F800000);
        rsp_ready = 1'b1;
        req_valid = 4'b0001;
        reached = 1'b0;
        for (int i = 0; i < 70000 && !reached; i++) begin
            tick();
            if (op_count == 16'hFFFF) reached = 1'b1;
        end
        req_valid = 4'b0000;
        checks++; if (!reached) begin errors++; $display("FAIL wrap_reach got %h want ffff", op_count); end
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", rsp_valid); end
        tick();
        checks++; if (op_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got %h want 0000", op_count); end
        tick();
        checks++; if (op_count !== 16'h0001) begin errors++; $display("FAIL wrap_one got %h want 0001", op_count); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_contention();
        test_back_to_back_backpressure();
        test_special();
        test_reset_midflight();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
